// File: rtl/abro_n_module.sv
// N-input ABRO controller: waits until every event input has been seen at least
// once in any order, emits a one-cycle pulse, then halts until r or re-arms.
module abro_n_module #(
    parameter int unsigned N     = 4,
    parameter int unsigned REARM = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in,
    input  logic             r,
    output logic             o,
    output logic [1:0]       state,
    output logic [N-1:0]     seen,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_EMIT = 2'b01,
        ST_HALT = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam logic [N-1:0]     ALL_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               AUTO_REARM = (REARM != 0);

    state_t             r_state;
    logic [N-1:0]       r_seen;
    logic               r_o;
    logic [CNT_W-1:0]   r_count;

    logic [N-1:0]       w_nxt;
    logic               w_full;
    logic [CNT_W-1:0]   w_count_inc;

    assign w_nxt       = r_seen | in;
    assign w_full      = (w_nxt == ALL_ONES);
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);

    // Restart beats completion beats accumulation; in is ignored outside WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_WAIT;
            r_seen  <= '0;
            r_o     <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r) begin
                        r_seen <= '0;
                        r_o    <= 1'b0;
                    end else if (w_full) begin
                        r_state <= ST_EMIT;
                        r_seen  <= ALL_ONES;
                        r_o     <= 1'b1;
                        r_count <= w_count_inc;
                    end else begin
                        r_seen <= w_nxt;
                        r_o    <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    r_o <= 1'b0;
                    if (r || AUTO_REARM) begin
                        r_state <= ST_WAIT;
                        r_seen  <= '0;
                    end else begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    r_o <= 1'b0;
                    if (r) begin
                        r_state <= ST_WAIT;
                        r_seen  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_WAIT;
                    r_seen  <= '0;
                    r_o     <= 1'b0;
                end
            endcase
        end
    end

    assign o     = r_o;
    assign state = r_state;
    assign seen  = r_seen;
    assign count = r_count;

endmodule
